spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Sequences single-byte SPI transactions and shares one SPI master among NUM_REQ requesters.
- Round-robin arbitration; each winner's slave-select and byte are presented to the master, which is started and then waited on for completion or timeout.
- The received byte or an error status is returned to the winner.
- Sits between the client logic and the SPI master/slave integration layer.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- NUM_SLAVES, 3, valid slave codes are 0..NUM_SLAVES-1; 3'b111 means no slave selected.
- TIMEOUT, 64, WAIT-state cycles before a transaction is aborted (at least 2).
- GAP_CYCLES, 2, idle cycles with SPI_SS=3'b111 between transactions (0 allowed).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- REQ  in  NUM_REQ  per-requester request level; held high until the matching ACK.
- REQ_SS  in  3*NUM_REQ  slave code per requester; requester i uses bits [3i+2:3i].
- REQ_DATA  in  8*NUM_REQ  TX byte per requester; requester i uses bits [8i+7:8i].
- GNT  out  NUM_REQ  one-hot grant, high SETUP through RESP.
- ACK  out  NUM_REQ  one-hot, one-cycle completion pulse.
- RSP_DATA  out  8  received byte, valid while ACK is high.
- RSP_ERR  out  1  error flag, valid while ACK is high.
- SPI_START  out  1  one-cycle start pulse to the master.
- SPI_SS  out  3  slave select to the master and slaves.
- SPI_DATA_M  out  8  TX byte to the master.
- SPI_DONE  in  1  one-cycle completion strobe from the master.
- SPI_DATA_S  in  8  RX byte, valid while SPI_DONE is high.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; rr pointer = 0; timeout and gap counters = 0.
  - GNT, ACK, RSP_DATA, RSP_ERR, SPI_START, SPI_DATA_M, BUSY = 0; SPI_SS = 3'b111.
- All outputs are registered.
- States: IDLE, SETUP, WAIT, RESP, GAP.
- IDLE:
  - REQ is sampled only in IDLE.
  - If REQ != 0, pick the first set bit scanning upward from the rr pointer, wrapping mod NUM_REQ.
  - Latch winner index, its REQ_SS and its REQ_DATA, then go to SETUP.
- SETUP (exactly one cycle; GNT[idx] = 1, BUSY = 1):
  - If the latched SS is 3'b111 or >= NUM_SLAVES: no SPI_START, SPI_SS stays 3'b111, RSP_ERR = 1, RSP_DATA = 0, go to RESP.
  - Otherwise: SPI_SS = latched SS, SPI_DATA_M = latched byte, SPI_START = 1 for this cycle only, clear timeout counter, go to WAIT.
- WAIT:
  - SPI_SS and SPI_DATA_M are held; the timeout counter increments each cycle.
  - SPI_DONE = 1: capture SPI_DATA_S into RSP_DATA, RSP_ERR = 0, go to RESP.
  - Counter reaches TIMEOUT-1 without SPI_DONE: RSP_DATA = 0, RSP_ERR = 1, go to RESP.
  - SPI_DONE and timeout in the same cycle: SPI_DONE wins.
- RESP (one cycle):
  - ACK[idx] = 1 with RSP_DATA and RSP_ERR valid.
  - SPI_SS = 3'b111.
  - rr pointer = (idx+1) mod NUM_REQ.
  - Go to GAP, or to IDLE if GAP_CYCLES = 0.
- GAP: hold SPI_SS = 3'b111 for GAP_CYCLES cycles, then go to IDLE.
- Latency:
  - REQ high in IDLE at cycle t gives SPI_START at t+1.
  - SPI_DONE at cycle d gives ACK at d+1.
  - Fastest back-to-back restart: ACK cycle + GAP_CYCLES + 1.
- The winner dropping REQ mid-transaction is ignored: the transaction completes and ACK still pulses.
- Changes to REQ_SS or REQ_DATA after latching have no effect.
- SPI_DONE outside WAIT is ignored.
- Exactly one ACK per grant, and never more than one GNT bit high.
- Reset asserted in any state forces the reset values immediately: SPI_SS = 3'b111, any in-flight ACK is lost, pointer = 0.
- Counters are sized by clog2; no counter wraps.

Decomposition:
- Package spi_ctrl_pkg:
  - state enum (IDLE/SETUP/WAIT/RESP/GAP, 3-bit);
  - SS_NONE = 3'b111;
  - SS_W = 3, DATA_W = 8.
- Sub-module spi_rr_pick: combinational round-robin picker.
  - Inputs: REQ vector and pointer.
  - Outputs: one-hot winner, binary index, any-valid flag.
  - Verified standalone.

Test Plan:
- Reset: drive RST_N low mid-stream -> SPI_SS = 3'b111, all other outputs 0, BUSY = 0, asynchronously before the next CLK edge.
- Single request: REQ = 3'b010, SS = 3'b001, DATA = 8'hA5; bench asserts SPI_DONE 4 cycles after SPI_START with SPI_DATA_S = 8'h3C.
  - Expect SPI_START one cycle after REQ with SPI_SS = 001 and SPI_DATA_M = A5.
  - Expect ACK = 3'b010 one cycle after DONE, RSP_DATA = 3C, RSP_ERR = 0.
- Round-robin: REQ = 3'b111 held, with each requester dropping its REQ after its ACK and re-raising it one cycle later, SS = 000/001/010 -> grant order 0,1,2,0.
  - Between grants, SPI_SS = 111 for at least 2 GAP cycles.
- Invalid select: REQ[0] with SS = 3'b111, then again with SS = 3'b011 -> no SPI_START, ACK[0] at SETUP+1 with RSP_ERR = 1, RSP_DATA = 0.
- Timeout and collision:
  - SPI_DONE never asserted -> ACK with RSP_ERR = 1 exactly TIMEOUT cycles after entering WAIT.
  - Repeat with SPI_DONE on the final WAIT cycle -> RSP_ERR = 0 and data captured.
- Reset mid-WAIT: assert RST_N low 2 cycles after SPI_START -> no ACK, pointer back to 0; next REQ = 3'b110 grants requester 1.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
// Holds the FSM state encoding and the slave-select helpers.
package spi_ctrl_pkg;

   localparam int SS_W   = 3;
   localparam int DATA_W = 8;

   localparam logic [SS_W-1:0] SS_NONE = 3'b111;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      GAP   = 3'd4
   } state_t;

   // A slave code is usable only if it names one of the fitted slaves.
   function automatic logic ss_ok(input logic [SS_W-1:0] ss,
                                  input int n);
      return (ss != SS_NONE) && (int'(ss) < n);
   endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker.
// Scans upward from ptr, wrapping, and returns the first request.
module spi_rr_pick #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   // First set bit at or above ptr, wrapping mod N.
   always_comb begin
      int j;
      j      = 0;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any       = 1'b1;
            onehot[j] = 1'b1;
            idx       = IW'(j);
         end
      end
   end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin sequencer sharing one SPI master among requesters.
// Runs one byte transaction per grant with timeout and idle gap.
module spi_txn_arbiter
   import spi_ctrl_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int NUM_SLAVES = 3,
   parameter int TIMEOUT    = 64,
   parameter int GAP_CYCLES = 2
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [NUM_REQ-1:0]        REQ,
   input  logic [SS_W*NUM_REQ-1:0]   REQ_SS,
   input  logic [DATA_W*NUM_REQ-1:0] REQ_DATA,
   output logic [NUM_REQ-1:0]        GNT,
   output logic [NUM_REQ-1:0]        ACK,
   output logic [DATA_W-1:0]         RSP_DATA,
   output logic                      RSP_ERR,
   output logic                      SPI_START,
   output logic [SS_W-1:0]           SPI_SS,
   output logic [DATA_W-1:0]         SPI_DATA_M,
   input  logic                      SPI_DONE,
   input  logic [DATA_W-1:0]         SPI_DATA_S,
   output logic                      BUSY
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_t          state;
   logic [IW-1:0]   rr;
   logic [IW-1:0]   idx;
   logic            ok_q;
   logic [TW-1:0]   tcnt;
   logic [GW-1:0]   gcnt;

   logic [NUM_REQ-1:0] pick_oh;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;
   logic [SS_W-1:0]    pick_ss;
   logic [DATA_W-1:0]  pick_data;
   logic               pick_ok;

   spi_rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req    (REQ),
      .ptr    (rr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Slave code and byte of the candidate winner.
   always_comb begin
      pick_ss   = REQ_SS[SS_W*pick_idx +: SS_W];
      pick_data = REQ_DATA[DATA_W*pick_idx +: DATA_W];
      pick_ok   = ss_ok(pick_ss, NUM_SLAVES);
   end

   // Transaction FSM; every output is set on entry to its state.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         rr         <= '0;
         idx        <= '0;
         ok_q       <= 1'b0;
         tcnt       <= '0;
         gcnt       <= '0;
         GNT        <= '0;
         ACK        <= '0;
         RSP_DATA   <= '0;
         RSP_ERR    <= 1'b0;
         SPI_START  <= 1'b0;
         SPI_SS     <= SS_NONE;
         SPI_DATA_M <= '0;
         BUSY       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  idx   <= pick_idx;
                  ok_q  <= pick_ok;
                  GNT   <= pick_oh;
                  BUSY  <= 1'b1;
                  if (pick_ok) begin
                     SPI_START  <= 1'b1;
                     SPI_SS     <= pick_ss;
                     SPI_DATA_M <= pick_data;
                  end
                  state <= SETUP;
               end
            end
            SETUP: begin
               SPI_START <= 1'b0;
               if (!ok_q) begin
                  ACK      <= GNT;
                  RSP_ERR  <= 1'b1;
                  RSP_DATA <= '0;
                  state    <= RESP;
               end else begin
                  tcnt  <= '0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (SPI_DONE) begin
                  ACK      <= GNT;
                  RSP_DATA <= SPI_DATA_S;
                  RSP_ERR  <= 1'b0;
                  SPI_SS   <= SS_NONE;
                  state    <= RESP;
               end else if (int'(tcnt) == TIMEOUT - 1) begin
                  ACK      <= GNT;
                  RSP_DATA <= '0;
                  RSP_ERR  <= 1'b1;
                  SPI_SS   <= SS_NONE;
                  state    <= RESP;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            RESP: begin
               ACK      <= '0;
               GNT      <= '0;
               RSP_DATA <= '0;
               RSP_ERR  <= 1'b0;
               rr       <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
               if (GAP_CYCLES == 0) begin
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gcnt  <= '0;
                  state <= GAP;
               end
            end
            GAP: begin
               if (int'(gcnt) == GAP_CYCLES - 1) begin
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gcnt <= gcnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter.
// A cycle-indexed expected timeline is planned per transaction.
module tb_spi_txn_arbiter;

   localparam int N    = 3;
   localparam int TO   = 64;
   localparam int G    = 2;
   localparam int MAXC = 2000;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [2:0]  REQ;
   logic [8:0]  REQ_SS;
   logic [23:0] REQ_DATA;
   logic [2:0]  GNT;
   logic [2:0]  ACK;
   logic [7:0]  RSP_DATA;
   logic        RSP_ERR;
   logic        SPI_START;
   logic [2:0]  SPI_SS;
   logic [7:0]  SPI_DATA_M;
   logic        SPI_DONE;
   logic [7:0]  SPI_DATA_S;
   logic        BUSY;

   spi_txn_arbiter #(
      .NUM_REQ    (N),
      .NUM_SLAVES (3),
      .TIMEOUT    (TO),
      .GAP_CYCLES (G)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .REQ        (REQ),
      .REQ_SS     (REQ_SS),
      .REQ_DATA   (REQ_DATA),
      .GNT        (GNT),
      .ACK        (ACK),
      .RSP_DATA   (RSP_DATA),
      .RSP_ERR    (RSP_ERR),
      .SPI_START  (SPI_START),
      .SPI_SS     (SPI_SS),
      .SPI_DATA_M (SPI_DATA_M),
      .SPI_DONE   (SPI_DONE),
      .SPI_DATA_S (SPI_DATA_S),
      .BUSY       (BUSY)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc++;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   logic [2:0] e_gnt [MAXC];
   logic [2:0] e_ack [MAXC];
   logic       e_st  [MAXC];
   logic       e_bsy [MAXC];
   logic [2:0] e_ss  [MAXC];
   logic [7:0] e_dm  [MAXC];
   logic [7:0] e_rd  [MAXC];
   logic       e_re  [MAXC];

   logic [2:0] tb_ss   [N];
   logic [7:0] tb_data [N];
   int rr      = 0;
   int free_at = 0;

   int st_cyc  = -1;
   int ack_cyc = -1;
   logic [7:0] ack_rd;
   logic       ack_re;
   logic [2:0] ack_q [$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   // Per-cycle comparison against the planned timeline.
   always @(negedge CLK) begin
      if (cmp_en && cyc < MAXC) begin
         chk("gnt", GNT, e_gnt[cyc]);
         chk("ack", ACK, e_ack[cyc]);
         chk("start", SPI_START, e_st[cyc]);
         chk("busy", BUSY, e_bsy[cyc]);
         chk("ss", SPI_SS, e_ss[cyc]);
         chk("data_m", SPI_DATA_M, e_dm[cyc]);
         if (e_ack[cyc] != 3'b000) begin
            chk("rsp_data", RSP_DATA, e_rd[cyc]);
            chk("rsp_err", RSP_ERR, e_re[cyc]);
         end
      end
   end

   // Observed event log used by the literal checks.
   always @(negedge CLK) begin
      if (SPI_START) st_cyc = cyc;
      if (ACK != 3'b000) begin
         ack_cyc = cyc;
         ack_rd  = RSP_DATA;
         ack_re  = RSP_ERR;
         ack_q.push_back(ACK);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_idle(input int from);
      for (int c = from; c < MAXC; c++) begin
         e_gnt[c] = 3'b000;
         e_ack[c] = 3'b000;
         e_st[c]  = 1'b0;
         e_bsy[c] = 1'b0;
         e_ss[c]  = 3'b111;
         e_rd[c]  = 8'h00;
         e_re[c]  = 1'b0;
      end
   endtask

   task automatic fill_dm(input int from, input logic [7:0] v);
      for (int c = from; c < MAXC; c++) e_dm[c] = v;
   endtask

   // Expected timeline of one transaction sampled in IDLE at cycle t.
   task automatic plan(input int t, input logic [2:0] mask,
                       input int done_k, input logic [7:0] rx,
                       output int w, output int a);
      int s;
      bit ok;
      logic [2:0] ss;
      w = -1;
      for (int k = 0; k < N; k++) begin
         if (w < 0 && mask[(rr + k) % N]) w = (rr + k) % N;
      end
      ss = tb_ss[w];
      ok = (ss != 3'b111) && (ss < 3'd3);
      s  = t + 1;
      e_gnt[s] = 3'(1 << w);
      e_bsy[s] = 1'b1;
      e_st[s]  = ok;
      e_ss[s]  = ok ? ss : 3'b111;
      if (ok) begin
         fill_dm(s, tb_data[w]);
         a = (done_k > 0) ? s + done_k + 1 : s + 1 + TO;
         for (int c = s + 1; c < a; c++) begin
            e_gnt[c] = 3'(1 << w);
            e_bsy[c] = 1'b1;
            e_ss[c]  = ss;
         end
      end else begin
         a = s + 1;
      end
      e_gnt[a] = 3'(1 << w);
      e_ack[a] = 3'(1 << w);
      e_bsy[a] = 1'b1;
      e_rd[a]  = (ok && done_k > 0) ? rx : 8'h00;
      e_re[a]  = !(ok && done_k > 0);
      for (int c = a + 1; c <= a + G; c++) e_bsy[c] = 1'b1;
      free_at = a + G + 1;
      rr = (w + 1) % N;
   endtask

   task automatic drive_req_bus();
      for (int i = 0; i < N; i++) begin
         REQ_SS[3*i +: 3]   = tb_ss[i];
         REQ_DATA[8*i +: 8] = tb_data[i];
      end
   endtask

   task automatic run_txn(input logic [2:0] mask, input int done_k,
                          input logic [7:0] rx, input bit reraise,
                          output int t, output int a);
      int w;
      int s;
      while (cyc < free_at) tick();
      t = cyc;
      drive_req_bus();
      REQ = mask;
      plan(t, mask, done_k, rx, w, a);
      s = t + 1;
      tick();
      REQ_SS   = ~REQ_SS;
      REQ_DATA = ~REQ_DATA;
      while (cyc <= a) begin
         if (done_k > 0 && cyc == s + done_k) begin
            SPI_DONE   = 1'b1;
            SPI_DATA_S = rx;
         end else begin
            SPI_DONE   = 1'b0;
            SPI_DATA_S = 8'hEE;
         end
         tick();
      end
      if (reraise) begin
         REQ[w] = 1'b0;
         tick();
         REQ[w] = 1'b1;
      end else begin
         REQ = 3'b000;
      end
   endtask

   task automatic mid_reset();
      RST_N    = 1'b0;
      REQ      = 3'b000;
      SPI_DONE = 1'b0;
      set_idle(cyc);
      fill_dm(cyc, 8'h00);
      rr = 0;
      #1;
      chk("arst_ss", SPI_SS, 3'b111);
      chk("arst_gnt", GNT, 3'b000);
      chk("arst_ack", ACK, 3'b000);
      chk("arst_start", SPI_START, 1'b0);
      chk("arst_busy", BUSY, 1'b0);
      chk("arst_dm", SPI_DATA_M, 8'h00);
      tick();
      tick();
      RST_N   = 1'b1;
      free_at = cyc;
   endtask

   int t;
   int a;
   int n0;

   initial begin
      REQ        = 3'b000;
      REQ_SS     = '0;
      REQ_DATA   = '0;
      SPI_DONE   = 1'b0;
      SPI_DATA_S = 8'h00;
      for (int i = 0; i < N; i++) begin
         tb_ss[i]   = 3'b000;
         tb_data[i] = 8'h00;
      end
      set_idle(0);
      fill_dm(0, 8'h00);

      repeat (3) tick();
      chk("rst_ss", SPI_SS, 3'b111);
      chk("rst_gnt", GNT, 3'b000);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_rsp", {ACK, RSP_DATA, RSP_ERR}, 12'h000);
      RST_N   = 1'b1;
      cmp_en  = 1'b1;
      free_at = cyc;

      SPI_DONE   = 1'b1;
      SPI_DATA_S = 8'h77;
      tick();
      SPI_DONE   = 1'b0;
      free_at    = cyc;

      tb_ss[1]   = 3'b001;
      tb_data[1] = 8'hA5;
      run_txn(3'b010, 4, 8'h3C, 1'b0, t, a);
      chk("single_start_lat", st_cyc - t, 1);
      chk("single_ack_lat", ack_cyc - t, 6);
      chk("single_ack", ack_q[ack_q.size()-1], 3'b010);
      chk("single_rd", ack_rd, 8'h3C);
      chk("single_re", ack_re, 1'b0);

      tb_ss[0] = 3'b000;  tb_data[0] = 8'h11;
      tb_ss[2] = 3'b010;  tb_data[2] = 8'h33;
      tb_data[1] = 8'h22;
      run_txn(3'b100, 1, 8'h5A, 1'b0, t, a);

      ack_q.delete();
      run_txn(3'b111, 2, 8'hC1, 1'b1, t, a);
      run_txn(3'b111, 3, 8'hC2, 1'b1, t, a);
      run_txn(3'b111, 1, 8'hC3, 1'b1, t, a);
      run_txn(3'b111, 5, 8'hC4, 1'b0, t, a);
      chk("rr_count", ack_q.size(), 4);
      if (ack_q.size() == 4) begin
         chk("rr_0", ack_q[0], 3'b001);
         chk("rr_1", ack_q[1], 3'b010);
         chk("rr_2", ack_q[2], 3'b100);
         chk("rr_3", ack_q[3], 3'b001);
      end

      tb_ss[0] = 3'b111;
      run_txn(3'b001, 0, 8'h00, 1'b0, t, a);
      chk("inv7_nostart", st_cyc < t, 1'b1);
      chk("inv7_ack_lat", ack_cyc - t, 2);
      chk("inv7_re", ack_re, 1'b1);
      chk("inv7_rd", ack_rd, 8'h00);
      tb_ss[0] = 3'b011;
      run_txn(3'b001, 0, 8'h00, 1'b0, t, a);
      chk("inv3_nostart", st_cyc < t, 1'b1);
      chk("inv3_ack_lat", ack_cyc - t, 2);
      chk("inv3_re", ack_re, 1'b1);

      tb_data[2] = 8'hC3;
      run_txn(3'b100, 0, 8'h00, 1'b0, t, a);
      chk("to_lat", ack_cyc - st_cyc, 65);
      chk("to_re", ack_re, 1'b1);
      chk("to_rd", ack_rd, 8'h00);
      run_txn(3'b100, 64, 8'h96, 1'b0, t, a);
      chk("col_lat", ack_cyc - st_cyc, 65);
      chk("col_re", ack_re, 1'b0);
      chk("col_rd", ack_rd, 8'h96);

      run_txn(3'b010, 3, 8'h44, 1'b0, t, a);
      tb_ss[0]   = 3'b000;
      tb_data[0] = 8'h5C;
      n0 = ack_q.size();
      while (cyc < free_at) tick();
      t = cyc;
      drive_req_bus();
      REQ = 3'b001;
      begin
         int w;
         plan(t, 3'b001, 0, 8'h00, w, a);
      end
      tick();
      tick();
      tick();
      mid_reset();
      tb_ss[1]   = 3'b010;
      tb_data[1] = 8'h6B;
      tb_ss[2]   = 3'b001;
      run_txn(3'b110, 2, 8'h81, 1'b0, t, a);
      chk("rst_no_lost_ack", ack_q.size() - n0, 1);
      chk("rst_ptr_grant", ack_q[ack_q.size()-1], 3'b010);
      chk("rst_rd", ack_rd, 8'h81);

      repeat (4) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
